// File: rtl/gtech_muxi_n_reg_if.sv
// gtech_muxi_n_reg_if: select handshake, channel data and registered mux result bundle
interface gtech_muxi_n_reg_if #(
  parameter int NCH = 4,
  parameter int WIDTH = 8
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  logic [NCH*WIDTH-1:0] D;
  logic [SW-1:0] SEL;
  logic SEL_VLD;
  logic SEL_RDY;
  logic INV;
  logic [WIDTH-1:0] Z;
  logic Z_VLD;
  logic [SW-1:0] CUR_SEL;
  logic SEL_ERR;
  modport master (
    output D, SEL, SEL_VLD, INV,
    input SEL_RDY, Z, Z_VLD, CUR_SEL, SEL_ERR
  );
  modport slave (
    input D, SEL, SEL_VLD, INV,
    output SEL_RDY, Z, Z_VLD, CUR_SEL, SEL_ERR
  );
endinterface

// File: rtl/gtech_muxi_n_reg.sv
// gtech_muxi_n_reg: registered N:1 inverting mux with handshaked channel change and blanking gap
module gtech_muxi_n_reg #(
  parameter int NCH = 4,
  parameter int WIDTH = 8,
  parameter int GAP = 2
) (
  input logic CLK,
  input logic RST,
  gtech_muxi_n_reg_if.slave bus
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0] GAP_M1 = 4'((GAP > 0) ? GAP - 1 : 0);
  typedef enum logic {RUN, BLANK} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [WIDTH-1:0] z_q, z_n, live, fresh;
  logic [SW-1:0] cur_q, cur_n;
  logic vld_q, vld_n, err_q, err_n;
  logic sel_ok, accept, chg;
  // Decoded lookup so an unused select code can never address outside D
  function automatic logic [WIDTH-1:0] pick(input logic [NCH*WIDTH-1:0] d, input logic [SW-1:0] idx);
    pick = '0;
    for (int i = 0; i < NCH; i++)
      if (idx == SW'(i)) pick = d[i*WIDTH +: WIDTH];
  endfunction
  if ((1 << SW) == NCH) begin : g_pow2
    assign sel_ok = 1'b1;
  end else begin : g_npow2
    assign sel_ok = bus.SEL < SW'(NCH);
  end
  assign bus.SEL_RDY = state == RUN;
  assign accept = bus.SEL_VLD & bus.SEL_RDY;
  assign chg = accept & sel_ok & (bus.SEL != cur_q);
  assign live = bus.INV ? ~pick(bus.D, cur_q) : pick(bus.D, cur_q);
  assign fresh = bus.INV ? ~pick(bus.D, bus.SEL) : pick(bus.D, bus.SEL);
  // Blanking control: a real channel change with a nonzero gap parks the block in BLANK
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // Next state: leave BLANK on the edge that finds the counter already at zero
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == RUN) begin
      if (chg && GAP != 0) begin
        state_n = BLANK;
        cnt_n = GAP_M1;
      end
    end else if (cnt != 4'd0) begin
      cnt_n = cnt - 4'd1;
    end else begin
      state_n = RUN;
    end
  end
  // Output next values: sample the live channel, bypass on a zero-gap change, hold while blanked
  always_comb begin
    cur_n = chg ? bus.SEL : cur_q;
    err_n = accept & ~sel_ok;
    z_n = z_q;
    vld_n = 1'b0;
    if (state == RUN) begin
      z_n = chg ? ((GAP == 0) ? fresh : z_q) : live;
      vld_n = !chg || GAP == 0;
    end else if (cnt == 4'd0) begin
      z_n = live;
      vld_n = 1'b1;
    end
  end
  // Registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      z_q <= '0;
      vld_q <= 1'b0;
      cur_q <= '0;
      err_q <= 1'b0;
    end else begin
      z_q <= z_n;
      vld_q <= vld_n;
      cur_q <= cur_n;
      err_q <= err_n;
    end
  end
  assign bus.Z = z_q;
  assign bus.Z_VLD = vld_q;
  assign bus.CUR_SEL = cur_q;
  assign bus.SEL_ERR = err_q;
endmodule

// File: tb/tb_gtech_muxi_n_reg.sv
// tb_gtech_muxi_n_reg: directed vector bench for the main, 3-channel and zero-gap builds
module tb_gtech_muxi_n_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  gtech_muxi_n_reg_if #(.NCH(4), .WIDTH(8)) ia ();
  gtech_muxi_n_reg_if #(.NCH(3), .WIDTH(8)) ib ();
  gtech_muxi_n_reg_if #(.NCH(4), .WIDTH(8)) ic ();
  gtech_muxi_n_reg #(.NCH(4), .WIDTH(8), .GAP(2)) dut_a (.CLK(clk), .RST(rst), .bus(ia.slave));
  gtech_muxi_n_reg #(.NCH(3), .WIDTH(8), .GAP(2)) dut_b (.CLK(clk), .RST(rst), .bus(ib.slave));
  gtech_muxi_n_reg #(.NCH(4), .WIDTH(8), .GAP(0)) dut_c (.CLK(clk), .RST(rst), .bus(ic.slave));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [1:0] sel;
    logic sel_vld;
    logic inv;
    logic [7:0] z;
    logic z_vld;
    logic rdy;
    logic [1:0] cur;
    logic err;
  } vec_t;
  vec_t tbl [13];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic chk_a(input string tag, input logic [7:0] z, input logic v, input logic r, input logic [1:0] c, input logic e);
    chk({tag, " z"}, 32'(ia.Z), 32'(z));
    chk({tag, " z_vld"}, 32'(ia.Z_VLD), 32'(v));
    chk({tag, " sel_rdy"}, 32'(ia.SEL_RDY), 32'(r));
    chk({tag, " cur_sel"}, 32'(ia.CUR_SEL), 32'(c));
    chk({tag, " sel_err"}, 32'(ia.SEL_ERR), 32'(e));
  endtask
  initial begin
    tbl[0]  = '{sel: 2'd0, sel_vld: 1'b0, inv: 1'b1, z: 8'hA5, z_vld: 1'b1, rdy: 1'b1, cur: 2'd0, err: 1'b0};
    tbl[1]  = '{sel: 2'd2, sel_vld: 1'b1, inv: 1'b0, z: 8'hA5, z_vld: 1'b0, rdy: 1'b0, cur: 2'd2, err: 1'b0};
    tbl[2]  = '{sel: 2'd2, sel_vld: 1'b0, inv: 1'b0, z: 8'hA5, z_vld: 1'b0, rdy: 1'b0, cur: 2'd2, err: 1'b0};
    tbl[3]  = '{sel: 2'd2, sel_vld: 1'b0, inv: 1'b0, z: 8'h3C, z_vld: 1'b1, rdy: 1'b1, cur: 2'd2, err: 1'b0};
    tbl[4]  = '{sel: 2'd2, sel_vld: 1'b1, inv: 1'b1, z: 8'hC3, z_vld: 1'b1, rdy: 1'b1, cur: 2'd2, err: 1'b0};
    tbl[5]  = '{sel: 2'd2, sel_vld: 1'b1, inv: 1'b0, z: 8'h3C, z_vld: 1'b1, rdy: 1'b1, cur: 2'd2, err: 1'b0};
    tbl[6]  = '{sel: 2'd2, sel_vld: 1'b0, inv: 1'b1, z: 8'hC3, z_vld: 1'b1, rdy: 1'b1, cur: 2'd2, err: 1'b0};
    tbl[7]  = '{sel: 2'd1, sel_vld: 1'b1, inv: 1'b1, z: 8'hC3, z_vld: 1'b0, rdy: 1'b0, cur: 2'd1, err: 1'b0};
    tbl[8]  = '{sel: 2'd3, sel_vld: 1'b1, inv: 1'b0, z: 8'hC3, z_vld: 1'b0, rdy: 1'b0, cur: 2'd1, err: 1'b0};
    tbl[9]  = '{sel: 2'd3, sel_vld: 1'b0, inv: 1'b0, z: 8'h11, z_vld: 1'b1, rdy: 1'b1, cur: 2'd1, err: 1'b0};
    tbl[10] = '{sel: 2'd3, sel_vld: 1'b1, inv: 1'b1, z: 8'h11, z_vld: 1'b0, rdy: 1'b0, cur: 2'd3, err: 1'b0};
    tbl[11] = '{sel: 2'd3, sel_vld: 1'b0, inv: 1'b1, z: 8'h11, z_vld: 1'b0, rdy: 1'b0, cur: 2'd3, err: 1'b0};
    tbl[12] = '{sel: 2'd3, sel_vld: 1'b0, inv: 1'b1, z: 8'h0F, z_vld: 1'b1, rdy: 1'b1, cur: 2'd3, err: 1'b0};
    ia.D = 32'hF03C_115A;
    ia.SEL = 2'd0;
    ia.SEL_VLD = 1'b0;
    ia.INV = 1'b1;
    ib.D = 24'h3C_115A;
    ib.SEL = 2'd0;
    ib.SEL_VLD = 1'b0;
    ib.INV = 1'b0;
    ic.D = 32'h0000_815A;
    ic.SEL = 2'd0;
    ic.SEL_VLD = 1'b0;
    ic.INV = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    chk_a("reset", 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      ia.SEL = tbl[i].sel;
      ia.SEL_VLD = tbl[i].sel_vld;
      ia.INV = tbl[i].inv;
      step();
      chk_a($sformatf("v%0d", i), tbl[i].z, tbl[i].z_vld, tbl[i].rdy, tbl[i].cur, tbl[i].err);
    end
    ia.SEL = 2'd2;
    ia.SEL_VLD = 1'b1;
    ia.INV = 1'b0;
    step();
    chk_a("blank_entry", 8'h0F, 1'b0, 1'b0, 2'd2, 1'b0);
    ia.SEL_VLD = 1'b0;
    rst = 1'b1;
    #1;
    chk_a("async_rst", 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
    ia.SEL = 2'd2;
    ia.SEL_VLD = 1'b1;
    step();
    chk_a("rst_vs_req", 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
    rst = 1'b0;
    ia.SEL_VLD = 1'b0;
    ia.INV = 1'b1;
    step();
    chk_a("post_rst1", 8'hA5, 1'b1, 1'b1, 2'd0, 1'b0);
    step();
    chk_a("post_rst2", 8'hA5, 1'b1, 1'b1, 2'd0, 1'b0);
    chk("nch3 z", 32'(ib.Z), 32'h5A);
    ib.SEL = 2'd3;
    ib.SEL_VLD = 1'b1;
    step();
    chk("nch3 err_on", 32'(ib.SEL_ERR), 32'd1);
    chk("nch3 cur", 32'(ib.CUR_SEL), 32'd0);
    chk("nch3 z_vld", 32'(ib.Z_VLD), 32'd1);
    chk("nch3 rdy", 32'(ib.SEL_RDY), 32'd1);
    chk("nch3 z_keep", 32'(ib.Z), 32'h5A);
    ib.SEL_VLD = 1'b0;
    step();
    chk("nch3 err_off", 32'(ib.SEL_ERR), 32'd0);
    chk("nch3 z_vld2", 32'(ib.Z_VLD), 32'd1);
    chk("gap0 z_pre", 32'(ic.Z), 32'hA5);
    ic.SEL = 2'd1;
    ic.SEL_VLD = 1'b1;
    step();
    chk("gap0 z", 32'(ic.Z), 32'h7E);
    chk("gap0 z_vld", 32'(ic.Z_VLD), 32'd1);
    chk("gap0 rdy", 32'(ic.SEL_RDY), 32'd1);
    chk("gap0 cur", 32'(ic.CUR_SEL), 32'd1);
    ic.SEL_VLD = 1'b0;
    step();
    chk("gap0 z2", 32'(ic.Z), 32'h7E);
    chk("gap0 z_vld2", 32'(ic.Z_VLD), 32'd1);
    chk("gap0 rdy2", 32'(ic.SEL_RDY), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gtech_muxi_n_reg.md
Name: gtech_muxi_n_reg

Overview:
- Parametrised, registered N:1 multiplexer with per-cycle selectable output inversion. It is the sequential successor of the GTECH inverting 2:1 mux cell.
- Channel selection is changed through a valid/ready handshake, not a free-running select line.
- Every channel change goes through a programmable blanking gap, during which the output is flagged invalid.
- Used wherever a gate-level mux feeds synchronous logic that must never sample a mid-switch value.

Parameters:
- NCH, 4, number of input channels (>=2).
- WIDTH, 8, bit width of each channel and of Z.
- GAP, 2, blanking cycles inserted on a channel change (0..15).
- SW, max(1,clog2(NCH)), select width (localparam, derived, not overridable).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- D  input  NCH*WIDTH  channel data; channel i occupies D[i*WIDTH +: WIDTH].
- SEL  input  SW  requested channel index.
- SEL_VLD  input  1  select request valid.
- SEL_RDY  output  1  block can accept a select request.
- INV  input  1  1 = output is ~D[ch]; 0 = output is D[ch].
- Z  output  WIDTH  registered mux output.
- Z_VLD  output  1  Z holds a sample of the current channel.
- CUR_SEL  output  SW  currently active channel.
- SEL_ERR  output  1  one-cycle pulse when an out-of-range SEL is accepted.

Behaviour:
- Reset (asynchronous, while RST=1):
  - Z=0, Z_VLD=0, CUR_SEL=0, SEL_ERR=0, SEL_RDY=1.
  - State=RUN, blank counter=0.
- State RUN:
  - Each edge: Z <= INV ? ~D[CUR_SEL] : D[CUR_SEL], and Z_VLD <= 1.
  - Latency is 1 cycle from D and INV to Z.
  - The first edge after RST deasserts produces a valid Z from channel 0.
- SEL_RDY = (state==RUN), combinational from state.
- A request is accepted on an edge where SEL_VLD & SEL_RDY. SEL_VLD while SEL_RDY=0 is ignored; the requester holds SEL/SEL_VLD until accepted.
- Accepted request outcomes:
  - SEL >= NCH (only possible when NCH is not a power of 2): SEL_ERR=1 for one cycle. CUR_SEL unchanged, no blanking, Z continues normally.
  - SEL == CUR_SEL: no-op. Stays in RUN, no blanking, SEL_ERR=0.
  - SEL != CUR_SEL, GAP==0: CUR_SEL <= SEL. At the same edge Z <= f(D[SEL]) with Z_VLD=1, i.e. the new channel is bypass-sampled with no gap.
  - SEL != CUR_SEL, GAP>0: CUR_SEL <= SEL, Z holds its previous value, Z_VLD <= 0, counter <= GAP-1, state <= BLANK.
- State BLANK:
  - Z holds and Z_VLD=0; INV and D are ignored.
  - While counter>0, each edge decrements it.
  - On the edge with counter==0: Z <= f(D[CUR_SEL]), Z_VLD <= 1, state <= RUN.
  - Result: Z_VLD is low for exactly GAP cycles and SEL_RDY is low for exactly GAP cycles.
- SEL_ERR is registered, asserts on the edge after acceptance, and clears at the next edge.
- Reset asserted mid-BLANK: immediate return to reset values and state RUN. A pending blank is discarded.
- Simultaneous RST and SEL_VLD: reset wins; the request is not accepted.
- Z is never X after reset for known D. Unused SEL codes never index D.

Test Plan:
- NCH=4, WIDTH=8, GAP=2; D0=0x5A, INV=1, RST high then released -> during reset Z=0x00, Z_VLD=0. First edge after release: Z=0xA5, Z_VLD=1, CUR_SEL=0.
- From the previous scenario: D2=0x3C, INV=0, SEL=2 with SEL_VLD for 1 cycle -> SEL_RDY=0 and Z_VLD=0 for 2 cycles with Z held at 0xA5, CUR_SEL=2. Then Z=0x3C, Z_VLD=1, SEL_RDY=1.
- SEL=2 while CUR_SEL=2; toggle INV -> no blanking, SEL_RDY stays 1. Z alternates 0x3C/0xC3 one cycle after each INV change.
- NCH=3 build, SEL=3 accepted -> SEL_ERR high exactly 1 cycle, CUR_SEL unchanged, Z_VLD stays 1.
- GAP=0 build, D1=0x81, INV=1, SEL=1 accepted -> next edge Z=0x7E, Z_VLD=1, SEL_RDY never drops.
- GAP=2, RST asserted one cycle into BLANK -> asynchronously Z=0, Z_VLD=0, CUR_SEL=0, SEL_RDY=1. After release, Z follows channel 0 and no residual blank occurs.
